// File: rtl/ysyx_040750_store_wr_master_pkg.sv
// Shared types for the store write master: FSM encoding, AXI response codes, size-mask mapping.
// Pure declarations; no logic, no latency.
package ysyx_040750_store_wr_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ADDR_DATA = 2'd1,
    ST_WAIT_B    = 2'd2,
    ST_RESP      = 2'd3
  } wr_state_e;

  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

endpackage

// File: rtl/ysyx_040750_strb_align.sv
// Size mask + byte offset -> lane strobe, AXI size and misalign/bad-mask flag.
// Purely combinational (zero latency, no backpressure); shared with the load path.
module ysyx_040750_strb_align
  import ysyx_040750_store_wr_master_pkg::*;
(
  input  logic [7:0] i_mask,
  input  logic [2:0] i_off,
  output logic [7:0] o_strb,
  output logic [2:0] o_size,
  output logic       o_bad
);

  logic [15:0] w_lane;
  logic        w_mask_ok;

  // Any strobe bit pushed past lane 7 means the access crosses the 8-byte beat.
  assign w_lane = {8'h00, i_mask} << i_off;

  always_comb begin
    w_mask_ok = 1'b1;
    o_size    = SIZE_B;
    case (i_mask)
      MASK_B:  o_size = SIZE_B;
      MASK_H:  o_size = SIZE_H;
      MASK_W:  o_size = SIZE_W;
      MASK_D:  o_size = SIZE_D;
      default: w_mask_ok = 1'b0;
    endcase
  end

  assign o_strb = w_lane[7:0];
  assign o_bad  = !w_mask_ok || (w_lane[15:8] != 8'h00);

endmodule

// File: rtl/ysyx_040750_store_wr_master.sv
// Single-beat AXI4 store write master; done 3 cycles after accept (zero-wait slave), 1 on error.
// Accepts only in IDLE (one outstanding); optional B timeout via YSYX_040750_WR_TIMEOUT_EN.
module ysyx_040750_store_wr_master
  import ysyx_040750_store_wr_master_pkg::*;
#(
  parameter int         ADDR_W      = 32,
  parameter logic [3:0] AXI_ID      = 4'd1,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic              I_sys_clk,
  input  logic              I_rst_n,
  input  logic              I_st_valid,
  output logic              O_st_ready,
  input  logic [ADDR_W-1:0] I_st_addr,
  input  logic [63:0]       I_st_data,
  input  logic [7:0]        I_st_strb,
  output logic              O_st_done,
  output logic              O_st_err,
  output logic              O_awvalid,
  input  logic              I_awready,
  output logic [ADDR_W-1:0] O_awaddr,
  output logic [3:0]        O_awid,
  output logic [2:0]        O_awsize,
  output logic              O_wvalid,
  input  logic              I_wready,
  output logic [63:0]       O_wdata,
  output logic [7:0]        O_wstrb,
  output logic              O_wlast,
  input  logic              I_bvalid,
  output logic              O_bready,
  input  logic [1:0]        I_bresp
);

  wr_state_e         r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_data;
  logic [7:0]        r_strb;
  logic [2:0]        r_size;
  logic              r_err, r_aw_done, r_w_done;

  logic [7:0] w_strb;
  logic [2:0] w_size;
  logic       w_bad, w_accept, w_aw_hs, w_w_hs, w_b_hs, w_b_err, w_timeout;

  ysyx_040750_strb_align u_align (
    .i_mask (I_st_strb),
    .i_off  (I_st_addr[2:0]),
    .o_strb (w_strb),
    .o_size (w_size),
    .o_bad  (w_bad)
  );

  // Valids are decoded from the async-reset state so reset drops them immediately.
  assign O_st_ready = (r_state == ST_IDLE);
  assign O_awvalid  = (r_state == ST_ADDR_DATA) && !r_aw_done;
  assign O_wvalid   = (r_state == ST_ADDR_DATA) && !r_w_done;
  assign O_wlast    = O_wvalid;
  assign O_bready   = (r_state == ST_WAIT_B);
  assign O_st_done  = (r_state == ST_RESP);
  assign O_st_err   = O_st_done && r_err;
  assign O_awaddr   = r_addr;
  assign O_awid     = AXI_ID;
  assign O_awsize   = r_size;
  assign O_wdata    = r_data;
  assign O_wstrb    = r_strb;

  assign w_accept = I_st_valid && O_st_ready;
  assign w_aw_hs  = O_awvalid && I_awready;
  assign w_w_hs   = O_wvalid && I_wready;
  assign w_b_hs   = O_bready && I_bvalid;
  assign w_b_err  = (I_bresp == AXI_RESP_SLVERR) || (I_bresp == AXI_RESP_DECERR);

`ifdef YSYX_040750_WR_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [CNT_W-1:0] r_tcnt;

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n)                 r_tcnt <= '0;
    else if (r_state != ST_WAIT_B) r_tcnt <= '0;
    else                          r_tcnt <= r_tcnt + 1'b1;
  end

  // Fires on the last allowed WAIT_B cycle, so RESP lands TIMEOUT_CYC cycles after entry.
  assign w_timeout = (r_state == ST_WAIT_B) && !I_bvalid &&
                     (r_tcnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC == 0);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (I_st_valid) w_next = w_bad ? ST_RESP : ST_ADDR_DATA;
      ST_ADDR_DATA: if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = ST_WAIT_B;
      ST_WAIT_B:    if (w_b_hs || w_timeout) w_next = ST_RESP;
      ST_RESP:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_addr    <= '0;
      r_data    <= '0;
      r_strb    <= '0;
      r_size    <= '0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= I_st_addr;
        r_data <= I_st_data;
        r_strb <= w_strb;
        r_size <= w_size;
        r_err  <= w_bad;
      end else if (w_b_hs) begin
        r_err <= w_b_err;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (r_state != ST_ADDR_DATA) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_040750_store_wr_master.sv
// Scoreboard bench for the store write master with a cycle-scripted AXI slave.
`timescale 1ns/1ps
module tb_ysyx_040750_store_wr_master;

  logic        I_sys_clk = 1'b0;
  logic        I_rst_n   = 1'b0;
  logic        I_st_valid = 1'b0;
  logic        O_st_ready;
  logic [31:0] I_st_addr = '0;
  logic [63:0] I_st_data = '0;
  logic [7:0]  I_st_strb = '0;
  logic        O_st_done, O_st_err;
  logic        O_awvalid;
  logic        I_awready = 1'b0;
  logic [31:0] O_awaddr;
  logic [3:0]  O_awid;
  logic [2:0]  O_awsize;
  logic        O_wvalid;
  logic        I_wready = 1'b0;
  logic [63:0] O_wdata;
  logic [7:0]  O_wstrb;
  logic        O_wlast;
  logic        I_bvalid = 1'b0;
  logic        O_bready;
  logic [1:0]  I_bresp = 2'b00;

  always #5 I_sys_clk = ~I_sys_clk;

  ysyx_040750_store_wr_master #(
    .ADDR_W(32), .AXI_ID(4'd1), .TIMEOUT_CYC(4)
  ) u_dut (
    .I_sys_clk(I_sys_clk), .I_rst_n(I_rst_n),
    .I_st_valid(I_st_valid), .O_st_ready(O_st_ready),
    .I_st_addr(I_st_addr), .I_st_data(I_st_data), .I_st_strb(I_st_strb),
    .O_st_done(O_st_done), .O_st_err(O_st_err),
    .O_awvalid(O_awvalid), .I_awready(I_awready), .O_awaddr(O_awaddr),
    .O_awid(O_awid), .O_awsize(O_awsize),
    .O_wvalid(O_wvalid), .I_wready(I_wready), .O_wdata(O_wdata),
    .O_wstrb(O_wstrb), .O_wlast(O_wlast),
    .I_bvalid(I_bvalid), .O_bready(O_bready), .I_bresp(I_bresp)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [2:0]  size;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference lane/size mapping; err marks requests that must never reach the bus.
  function automatic exp_t model(input logic [31:0] addr, input logic [63:0] data,
                                 input logic [7:0] mask);
    exp_t        e;
    logic [15:0] lane;
    lane   = {8'h00, mask} << addr[2:0];
    e.addr = addr;
    e.data = data;
    e.strb = lane[7:0];
    e.err  = 1'b0;
    case (mask)
      8'h01:   e.size = 3'd0;
      8'h03:   e.size = 3'd1;
      8'h0F:   e.size = 3'd2;
      8'hFF:   e.size = 3'd3;
      default: begin e.size = 3'd0; e.err = 1'b1; end
    endcase
    if (lane[15:8] != 8'h00) e.err = 1'b1;
    return e;
  endfunction

  // Cycle 0 = accept cycle. Slave readies rise at aw_at/w_at; bvalid comes b_dly
  // cycles after the later handshake (b_dly<0: never). rst_at>0 pulses reset there.
  task automatic run_store(input logic [31:0] addr, input logic [63:0] data,
                           input logic [7:0] mask, input int aw_at, input int w_at,
                           input int b_dly, input logic [1:0] bresp, input int rst_at,
                           input logic exp_err, input int exp_done);
    exp_t e;
    bit   axi, fin, b_done;
    int   aw_v, w_v, aw_n, w_n, aw_c, w_c, first_br, last_hs;
    fin = 0; b_done = 0;
    aw_v = 0; w_v = 0; aw_n = 0; w_n = 0; aw_c = -1; w_c = -1; first_br = -1;
    @(negedge I_sys_clk);
    check("ready_idle", O_st_ready, 1);
    e     = model(addr, data, mask);
    axi   = !e.err;
    e.err = exp_err;
    sb_q.push_back(e);
    I_st_valid = 1'b1; I_st_addr = addr; I_st_data = data; I_st_strb = mask;
    I_awready = 1'b0; I_wready = 1'b0; I_bvalid = 1'b0; I_bresp = bresp;
    for (int c = 1; c <= 40 && !fin; c++) begin
      @(negedge I_sys_clk);
      I_st_valid = 1'b0;
      if (c == rst_at) begin
        check("bready_pre_rst", O_bready, 1);
        I_rst_n = 1'b0;
        #1;
        check("rst_awvalid", O_awvalid, 0);
        check("rst_wvalid", O_wvalid, 0);
        check("rst_bready", O_bready, 0);
        check("rst_done", O_st_done, 0);
        check("rst_ready", O_st_ready, 1);
        void'(sb_q.pop_front());
        I_awready = 1'b0; I_wready = 1'b0; I_bvalid = 1'b0;
        @(negedge I_sys_clk);
        I_rst_n = 1'b1;
        return;
      end
      if (O_awvalid) begin
        aw_v++;
        check("awaddr", O_awaddr, sb_q[0].addr);
        check("awsize", O_awsize, sb_q[0].size);
        check("awid", O_awid, 4'd1);
      end
      if (O_wvalid) begin
        w_v++;
        check("wdata", O_wdata, sb_q[0].data);
        check("wstrb", O_wstrb, sb_q[0].strb);
        check("wlast", O_wlast, 1);
      end
      if (O_bready && first_br < 0) first_br = c;
      if (O_st_done) begin
        fin = 1;
        check("done_cycle", c, exp_done);
        check("st_err", O_st_err, sb_q[0].err);
        void'(sb_q.pop_front());
      end
      last_hs    = (aw_c > w_c) ? aw_c : w_c;
      I_awready  = (c >= aw_at);
      I_wready   = (c >= w_at);
      I_bvalid   = !b_done && (b_dly >= 0) && (aw_c > 0) && (w_c > 0) && (c > last_hs + b_dly);
      if (O_awvalid && I_awready) begin aw_n++; aw_c = c; end
      if (O_wvalid && I_wready)   begin w_n++;  w_c = c; end
      if (O_bready && I_bvalid) b_done = 1;
    end
    I_awready = 1'b0; I_wready = 1'b0; I_bvalid = 1'b0;
    if (!fin) begin
      check("done_seen", 0, 1);
      void'(sb_q.pop_front());
    end
    check("aw_hs_count", aw_n, axi ? 1 : 0);
    check("w_hs_count", w_n, axi ? 1 : 0);
    if (axi) begin
      check("aw_hs_cycle", aw_c, aw_at);
      check("w_hs_cycle", w_c, w_at);
      check("awvalid_cycles", aw_v, aw_at);
      check("wvalid_cycles", w_v, w_at);
      check("bready_first", first_br, ((aw_at > w_at) ? aw_at : w_at) + 1);
    end
    @(negedge I_sys_clk);
    check("done_one_pulse", O_st_done, 0);
    check("ready_after", O_st_ready, 1);
  endtask

  initial begin
    repeat (3) @(negedge I_sys_clk);
    check("rst_st_ready", O_st_ready, 1);
    check("rst_awid", O_awid, 4'd1);
    check("rst_awvalid0", O_awvalid, 0);
    check("rst_wvalid0", O_wvalid, 0);
    check("rst_bready0", O_bready, 0);
    check("rst_done0", O_st_done, 0);
    check("rst_wstrb0", O_wstrb, 0);
    I_rst_n = 1'b1;

    //        addr          data                    mask   aw w  bd bresp rst err done
    run_store(32'h8000_0004, 64'h11223344_11223344, 8'h0F, 1, 1, 0, 2'b00, -1, 0, 3);
    run_store(32'h8000_0004, 64'hAABBCCDD_AABBCCDD, 8'h0F, 1, 4, 0, 2'b00, -1, 0, 6);
    run_store(32'h8000_0006, 64'h11223344_11223344, 8'h0F, 1, 1, 0, 2'b00, -1, 1, 1);
    run_store(32'h8000_0008, 64'h01234567_89ABCDEF, 8'hFF, 1, 1, 0, 2'b10, -1, 1, 3);
    run_store(32'h8000_0007, 64'h5A5A5A5A_5A5A5A5A, 8'h01, 1, 1, 0, 2'b00, -1, 0, 3);
    run_store(32'h8000_0002, 64'hBEEFBEEF_BEEFBEEF, 8'h03, 1, 1, 0, 2'b11, -1, 1, 3);
    run_store(32'h8000_0000, 64'h0,                 8'h07, 1, 1, 0, 2'b00, -1, 1, 1);
    run_store(32'h8000_0010, 64'hCAFEF00D_CAFEF00D, 8'h0F, 3, 1, 2, 2'b00, -1, 0, 7);
    run_store(32'h8000_0020, 64'h13579BDF_13579BDF, 8'hFF, 1, 1, -1, 2'b00, 3, 0, 0);
    run_store(32'h8000_0024, 64'h2468ACE0_2468ACE0, 8'h0F, 1, 1, 0, 2'b00, -1, 0, 3);
`ifdef YSYX_040750_WR_TIMEOUT_EN
    run_store(32'h8000_0030, 64'h77777777_77777777, 8'hFF, 1, 1, -1, 2'b00, -1, 1, 6);
    for (int k = 0; k < 3; k++) begin
      I_bvalid = 1'b1;
      @(negedge I_sys_clk);
      check("late_b_bready", O_bready, 0);
      check("late_b_done", O_st_done, 0);
      check("late_b_ready", O_st_ready, 1);
    end
    I_bvalid = 1'b0;
`endif
    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end

endmodule
